// File: rtl/j1_io_pkg.sv
// Shared constants for the j1 IO responder: address map, status bits, FSM encodings.
package j1_io_pkg;

   // One-hot address bits; a read ORs every selected field together.
   localparam logic [15:0] IO_GPIO_OUT   = 16'h0001;
   localparam logic [15:0] IO_GPIO_IN    = 16'h0002;
   localparam logic [15:0] IO_UART_DATA  = 16'h1000;
   localparam logic [15:0] IO_UART_STAT  = 16'h2000;
   localparam logic [15:0] IO_TMR_RELOAD = 16'h4000;
   localparam logic [15:0] IO_TMR_COUNT  = 16'h8000;

   // UART_STAT bit positions
   localparam int STAT_TX_READY  = 0;
   localparam int STAT_RX_VALID  = 1;
   localparam int STAT_OVERRUN   = 2;
   localparam int STAT_FRAME_ERR = 3;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/j1_uart.sv
// 8N1 UART with byte-level interface. TX line is registered; RX result is a
// one-cycle combinational strobe in the cycle the stop bit is sampled.
module j1_uart
   import j1_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       resetq,
   input  logic       tx_start,
   input  logic [7:0] tx_byte,
   output logic       tx_ready,
   output logic       uart_tx,
   input  logic       uart_rx,
   output logic       rx_strobe,
   output logic [7:0] rx_byte,
   output logic       rx_frame_err
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   tx_state_e     tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          tx_line_q, tx_line_d;
   logic          tx_bit_end;

   rx_state_e     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [1:0]    rx_sync_q;
   logic          rx_prev_q;
   logic          rx_s;
   logic          rx_bit_end;
   logic          rx_half;

   assign tx_bit_end = (tx_cnt_q == BIT_LAST);
   assign rx_s       = rx_sync_q[1];
   assign rx_bit_end = (rx_cnt_q == BIT_LAST);
   assign rx_half    = (rx_cnt_q == HALF_LAST);

   // TX state and datapath registers; the line idles high, also while in reset
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_line_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_line_q  <= tx_line_d;
      end
   end

   // TX next state: each non-idle state lasts one bit period
   always_comb begin
      tx_state_d = tx_state_q;
      case (tx_state_q)
         TX_IDLE:  if (tx_start) tx_state_d = TX_START;
         TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
         TX_DATA:  if (tx_bit_end && tx_bit_q == 3'd7) tx_state_d = TX_STOP;
         TX_STOP:  if (tx_bit_end) tx_state_d = TX_IDLE;
         default:  tx_state_d = TX_IDLE;
      endcase
   end

   // TX datapath: the line value for the next bit is loaded at each bit boundary
   always_comb begin
      tx_cnt_d   = (tx_state_q == TX_IDLE || tx_bit_end) ? '0 : tx_cnt_q + 1'b1;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_line_d  = tx_line_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (tx_start) begin
               tx_shift_d = tx_byte;
               tx_bit_d   = '0;
               tx_line_d  = 1'b0;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_line_d  = tx_shift_q[0];
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               if (tx_bit_q == 3'd7) begin
                  tx_line_d = 1'b1;
               end else begin
                  tx_line_d  = tx_shift_q[0];
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_bit_d   = tx_bit_q + 3'd1;
               end
            end
         end
         TX_STOP:  tx_line_d = 1'b1;
         default:  tx_line_d = 1'b1;
      endcase
   end

   // RX synchronizer, edge history and FSM registers
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_sync_q  <= 2'b11;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_sync_q  <= {rx_sync_q[0], uart_rx};
         rx_prev_q  <= rx_s;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // RX next state: falling edge starts, half-bit recheck filters glitches
   always_comb begin
      rx_state_d = rx_state_q;
      case (rx_state_q)
         RX_IDLE:  if (rx_prev_q && !rx_s) rx_state_d = RX_START;
         RX_START: if (rx_half) rx_state_d = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_bit_end && rx_bit_q == 3'd7) rx_state_d = RX_STOP;
         RX_STOP:  if (rx_bit_end) rx_state_d = RX_IDLE;
         default:  rx_state_d = RX_IDLE;
      endcase
   end

   // RX datapath: after the half-bit recheck, every full period lands mid-bit
   always_comb begin
      rx_cnt_d   = rx_cnt_q + 1'b1;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      case (rx_state_q)
         RX_IDLE:  begin rx_cnt_d = '0; rx_bit_d = '0; end
         RX_START: if (rx_half) rx_cnt_d = '0;
         RX_DATA: begin
            if (rx_bit_end) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
            end
         end
         RX_STOP:  if (rx_bit_end) rx_cnt_d = '0;
         default:  rx_cnt_d = '0;
      endcase
   end

   // Outputs
   always_comb begin
      tx_ready     = (tx_state_q == TX_IDLE);
      uart_tx      = tx_line_q;
      rx_byte      = rx_shift_q;
      rx_strobe    = (rx_state_q == RX_STOP) && rx_bit_end && rx_s;
      rx_frame_err = (rx_state_q == RX_STOP) && rx_bit_end && !rx_s;
   end

endmodule

// File: rtl/j1_io_responder.sv
// IO-space slave for the j1 core: GPIO, UART and periodic timer behind a
// one-hot address decode. Read data is combinational from mem_addr.
module j1_io_responder
   import j1_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int GPIO_W       = 8
) (
   input  logic              clk,
   input  logic              resetq,
   input  logic              io_rd,
   input  logic              io_wr,
   input  logic [15:0]       mem_addr,
   input  logic [15:0]       dout,
   output logic [15:0]       io_din,
   output logic              interrupt_request,
   input  logic              uart_rx,
   output logic              uart_tx,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out
);

   logic sel_gpio_out, sel_gpio_in, sel_uart_data, sel_uart_stat, sel_reload, sel_count;
   logic unused_addr_bits;

   logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
   logic [GPIO_W-1:0] gpio_s1_q, gpio_s2_q;

   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        overrun_q, overrun_d;
   logic        frame_err_q, frame_err_d;

   logic [15:0] reload_q, reload_d;
   logic [15:0] count_q, count_d;
   logic        pending_q, pending_d;

   logic        tx_start, tx_ready;
   logic        rx_strobe, rx_frame_err;
   logic [7:0]  rx_byte;
   logic        rd_data, rd_stat;
   logic [3:0]  stat;

   assign sel_gpio_out  = |(mem_addr & IO_GPIO_OUT);
   assign sel_gpio_in   = |(mem_addr & IO_GPIO_IN);
   assign sel_uart_data = |(mem_addr & IO_UART_DATA);
   assign sel_uart_stat = |(mem_addr & IO_UART_STAT);
   assign sel_reload    = |(mem_addr & IO_TMR_RELOAD);
   assign sel_count     = |(mem_addr & IO_TMR_COUNT);
   assign unused_addr_bits = ^mem_addr[11:2];

   assign rd_data  = io_rd && sel_uart_data;
   assign rd_stat  = io_rd && sel_uart_stat;
   // A busy transmitter ignores tx_start, which is how mid-frame writes get dropped
   assign tx_start = io_wr && sel_uart_data;

   j1_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
      .clk          (clk),
      .resetq       (resetq),
      .tx_start     (tx_start),
      .tx_byte      (dout[7:0]),
      .tx_ready     (tx_ready),
      .uart_tx      (uart_tx),
      .uart_rx      (uart_rx),
      .rx_strobe    (rx_strobe),
      .rx_byte      (rx_byte),
      .rx_frame_err (rx_frame_err)
   );

   // All responder state, including the GPIO input synchronizer
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         gpio_s1_q   <= '0;
         gpio_s2_q   <= '0;
         gpio_out_q  <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         reload_q    <= '0;
         count_q     <= '0;
         pending_q   <= 1'b0;
      end else begin
         gpio_s1_q   <= gpio_in;
         gpio_s2_q   <= gpio_s1_q;
         gpio_out_q  <= gpio_out_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         reload_q    <= reload_d;
         count_q     <= count_d;
         pending_q   <= pending_d;
      end
   end

   // GPIO output register write
   always_comb begin
      gpio_out_d = gpio_out_q;
      if (io_wr && sel_gpio_out) gpio_out_d = dout[GPIO_W-1:0];
   end

   // UART flags: a new event beats a clearing read in the same cycle
   always_comb begin
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q && !rd_data;
      overrun_d   = overrun_q && !rd_stat;
      frame_err_d = (frame_err_q && !rd_stat) || rx_frame_err;
      if (rx_strobe) begin
         rx_data_d  = rx_byte;
         rx_valid_d = 1'b1;
         if (rx_valid_q && !rd_data) overrun_d = 1'b1;
      end
   end

   // Timer: reload write restarts the count; expiry set wins over the ack
   always_comb begin
      reload_d  = reload_q;
      count_d   = count_q;
      pending_d = pending_q && !(io_wr && sel_count);
      if (io_wr && sel_reload) begin
         reload_d = dout;
         count_d  = dout;
      end else if (reload_q == '0) begin
         count_d = '0;
      end else if (count_q == '0) begin
         count_d   = reload_q;
         pending_d = 1'b1;
      end else begin
         count_d = count_q - 16'd1;
      end
   end

   // Read mux: OR of every selected field, independent of io_rd
   always_comb begin
      stat                 = '0;
      stat[STAT_TX_READY]  = tx_ready;
      stat[STAT_RX_VALID]  = rx_valid_q;
      stat[STAT_OVERRUN]   = overrun_q;
      stat[STAT_FRAME_ERR] = frame_err_q;
      io_din = '0;
      if (sel_gpio_out)  io_din[GPIO_W-1:0] = io_din[GPIO_W-1:0] | gpio_out_q;
      if (sel_gpio_in)   io_din[GPIO_W-1:0] = io_din[GPIO_W-1:0] | gpio_s2_q;
      if (sel_uart_data) io_din = io_din | {8'h00, rx_data_q};
      if (sel_uart_stat) io_din = io_din | {12'h000, stat};
      if (sel_reload)    io_din = io_din | reload_q;
      if (sel_count)     io_din = io_din | count_q;
   end

   assign gpio_out          = gpio_out_q;
   assign interrupt_request = pending_q;

endmodule
